// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port integer register file with per-register busy scoreboard
//
// Purpose:
//   NRD combinational read ports and one write-back port. A scoreboard bit per
//   register marks an issued-but-unwritten result so decode can stall on RAW
//   hazards. Register 0 is hardwired to zero and is never marked busy.
//
// Configuration:
//   REGFILE_BYPASS_EN  when defined, a same-cycle write-back is forwarded to the
//                      read ports and dbg_data, and rd_busy is masked for the
//                      forwarded register. When undefined, reads return the
//                      stored value and rd_busy reflects busy_vec only.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ra         read addresses, port k at [k*AW +: AW]
//   rdata      read data, port k at [k*XLEN +: XLEN]
//   rd_busy    port k's register has a pending result
//   we         write-back enable
//   rw         write-back address
//   wdata      write-back data
//   iss_valid  instruction with destination iss_rd issued this cycle
//   iss_rd     destination of the issued instruction
//   busy_vec   scoreboard bits, bit i = register i pending
//   busy_cnt   number of set bits in busy_vec
//   dbg_addr   debug read address
//   dbg_data   debug read data (combinational)

module regfile_sb #(
   parameter  int XLEN = 32,
   parameter  int AW   = 5,
   parameter  int NRD  = 2,
   parameter  int CNTW = 6,
   localparam int NREG = 1 << AW
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   ra,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rd_busy,
   input  logic                we,
   input  logic [AW-1:0]       rw,
   input  logic [XLEN-1:0]     wdata,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd,
   output logic [NREG-1:0]     busy_vec,
   output logic [CNTW-1:0]     busy_cnt,
   input  logic [AW-1:0]       dbg_addr,
   output logic [XLEN-1:0]     dbg_data
);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy_q;
   logic [CNTW-1:0] cnt_q;

   // Writes and issues that target x0 are discarded here, once, so every
   // consumer below can treat them as plain events.
   logic wr_hit;
   logic iss_hit;

   assign wr_hit  = we && (rw != '0);
   assign iss_hit = iss_valid && (iss_rd != '0);

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_hit) begin
         regs[rw] <= wdata;
      end
   end

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   logic [NREG-1:0] set_vec;
   logic [NREG-1:0] clr_vec;
   logic [NREG-1:0] busy_nxt;
   logic            cnt_inc;
   logic            cnt_dec;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_hit) begin
         set_vec[iss_rd] = 1'b1;
      end
      if (wr_hit) begin
         clr_vec[rw] = 1'b1;
      end
      // A new issue to the register being written means a newer producer is
      // in flight, so the set takes priority over the clear.
      busy_nxt    = set_vec | (busy_q & ~clr_vec);
      busy_nxt[0] = 1'b0;
   end

   // The count tracks popcount(busy_vec) incrementally: an issue only adds
   // when the bit was clear, and a write only subtracts when it actually
   // clears a set bit that is not simultaneously re-issued.
   assign cnt_inc = iss_hit && !busy_q[iss_rd];
   assign cnt_dec = wr_hit && busy_q[rw] && !(iss_hit && (iss_rd == rw));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_nxt;
         cnt_q  <= cnt_q + CNTW'(cnt_inc) - CNTW'(cnt_dec);
      end
   end

   assign busy_vec = busy_q;
   assign busy_cnt = cnt_q;

   // ------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
   // Forwarding is suppressed while reset is asserted so reads stay at zero.
   logic fwd_en;
   assign fwd_en = wr_hit && rst_n;
`endif

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] stored;

      assign addr   = ra[k*AW +: AW];
      assign stored = (addr == '0) ? '0 : regs[addr];

`ifdef REGFILE_BYPASS_EN
      logic fwd;
      assign fwd                      = fwd_en && (rw == addr);
      assign rdata[k*XLEN +: XLEN]    = fwd ? wdata : stored;
      assign rd_busy[k]               = busy_q[addr] && !fwd;
`else
      assign rdata[k*XLEN +: XLEN]    = stored;
      assign rd_busy[k]               = busy_q[addr];
`endif
   end

   // ------------------------------------------------------------------
   // Debug port
   // ------------------------------------------------------------------
   logic [XLEN-1:0] dbg_stored;

   assign dbg_stored = (dbg_addr == '0) ? '0 : regs[dbg_addr];

`ifdef REGFILE_BYPASS_EN
   assign dbg_data = (fwd_en && (rw == dbg_addr)) ? wdata : dbg_stored;
`else
   assign dbg_data = dbg_stored;
`endif

endmodule
